// File: rtl/led_pwm_regbank.sv
// rtl/led_pwm_regbank.sv - I2C-facing register bank with double-buffered PWM duty registers.
// Optional build macro: LED_PWM_AUTOCOMMIT_EN (write to the last duty register also commits).
module led_pwm_regbank #(
  parameter int          NUM_CH       = 8,
  parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rw,
  input  logic [7:0]            addr,
  input  logic                  wen,
  input  logic [7:0]            wdata,
  input  logic                  rdata_used,
  output logic [7:0]            rdata,
  input  logic                  period_end,
  output logic                  pwm_en,
  output logic [7:0]            prescale,
  output logic [NUM_CH*8-1:0]   duty_flat,
  output logic                  commit_pending
);

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_STATUS   = 8'h01;
  localparam logic [7:0] ADDR_PRESCALE = 8'h02;
  localparam logic [7:0] ADDR_COMMIT   = 8'h03;
  localparam logic [7:0] ADDR_LAST     = 8'(16 + NUM_CH - 1);

  logic [7:0] shadow [NUM_CH];
  logic [7:0] active [NUM_CH];
  logic       ctrl_sync;
  logic       done;
  logic [7:0] rd_val;
  logic       wr_ctrl, soft_rst, auto_hit, commit_wr;
  logic       xfer_period, xfer_imm, xfer, status_clr;
  logic       unused_rw;

  assign unused_rw = rw;

  assign wr_ctrl  = wen && (addr == ADDR_CTRL);
  assign soft_rst = wr_ctrl && wdata[7];

`ifdef LED_PWM_AUTOCOMMIT_EN
  assign auto_hit = wen && (addr == ADDR_LAST);
`else
  assign auto_hit = 1'b0;
`endif

  assign commit_wr   = (wen && (addr == ADDR_COMMIT)) || auto_hit;
  // An immediate-mode commit also services a pending transfer left over from SYNC=1.
  assign xfer_imm    = commit_wr && !ctrl_sync;
  assign xfer_period = period_end && commit_pending;
  assign xfer        = xfer_imm || xfer_period;
  assign status_clr  = rdata_used && (addr == ADDR_STATUS);

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      ADDR_CTRL:     rd_val = {6'b0, ctrl_sync, pwm_en};
      ADDR_STATUS:   rd_val = {6'b0, done, commit_pending};
      ADDR_PRESCALE: rd_val = prescale;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (addr == 8'(16 + i)) rd_val = shadow[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_en         <= 1'b0;
      ctrl_sync      <= 1'b0;
      prescale       <= PRESCALE_RST;
      commit_pending <= 1'b0;
      done           <= 1'b0;
      rdata          <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= 8'h00;
        active[i] <= 8'h00;
      end
    end else if (soft_rst) begin
      pwm_en         <= 1'b0;
      ctrl_sync      <= 1'b0;
      prescale       <= PRESCALE_RST;
      commit_pending <= 1'b0;
      done           <= 1'b0;
      rdata          <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= 8'h00;
        active[i] <= 8'h00;
      end
    end else begin
      rdata <= rd_val;
      if (wr_ctrl) begin
        pwm_en    <= wdata[0];
        ctrl_sync <= wdata[1];
      end
      if (wen && (addr == ADDR_PRESCALE)) prescale <= wdata;
      // Transfer copies the pre-edge shadows; an immediate-mode duty write then overrides its channel.
      for (int i = 0; i < NUM_CH; i++) begin
        if (xfer) active[i] <= shadow[i];
        if (wen && (addr == 8'(16 + i))) begin
          shadow[i] <= wdata;
          if (!ctrl_sync) active[i] <= wdata;
        end
      end
      if (xfer_imm)         commit_pending <= 1'b0;
      else if (commit_wr)   commit_pending <= 1'b1;
      else if (xfer_period) commit_pending <= 1'b0;
      if (xfer)             done <= 1'b1;
      else if (status_clr)  done <= 1'b0;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_flat
    assign duty_flat[8*n +: 8] = active[n];
  end

endmodule
